// File: rtl/uart_number_tx.sv
// rtl/uart_number_tx.sv - sends a latched hex number as uppercase ASCII 8N1 characters over a UART line.
// Define UART_NUMBER_TX_CRLF_EN to append CR, LF after the digits of every message.
module uart_number_tx #(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int BAUD_RATE                   = 115_200,
    parameter int NUMBER_OF_DIGITS            = 4,
    parameter int NUMBER_OF_BITS_PER_DIGIT    = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 send,
    input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
    output logic                                                 tx,
    output logic                                                 busy,
    output logic                                                 done
);

    localparam int CLKS_PER_BIT = BOARD_CLOCK_FREQUENCY_IN_HZ / BAUD_RATE;
`ifdef UART_NUMBER_TX_CRLF_EN
    localparam int NUM_CHARS = NUMBER_OF_DIGITS + 2;
`else
    localparam int NUM_CHARS = NUMBER_OF_DIGITS;
`endif
    localparam int NW = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(NUM_CHARS + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CHAR_LAST = CW'(NUM_CHARS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [CW-1:0]   r_char;
    logic [NW-1:0]   r_number;
    logic            r_done;
    logic            w_bit_end;
    logic            w_last_char;
    logic [3:0]      w_nibble;
    logic [7:0]      w_char;

    assign w_bit_end   = (r_baud == BAUD_LAST);
    assign w_last_char = (r_char == CHAR_LAST);
    // The latched number shifts left one digit per character, so the top nibble is always current.
    assign w_nibble    = r_number[NW-1 -: 4];
    assign done        = r_done;

    always_comb begin
        w_char = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble}) : (8'h37 + {4'h0, w_nibble});
`ifdef UART_NUMBER_TX_CRLF_EN
        if (r_char == CW'(NUMBER_OF_DIGITS)) begin
            w_char = 8'h0D;
        end else if (r_char == CW'(NUMBER_OF_DIGITS + 1)) begin
            w_char = 8'h0A;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_char  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_STOP) && (w_next == S_IDLE);
            if (r_state == S_IDLE || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
            if (r_state == S_DATA && w_bit_end) begin
                r_bit <= r_bit + 3'd1;
            end
            if (r_state == S_IDLE) begin
                r_char <= '0;
            end else if (r_state == S_STOP && w_bit_end) begin
                r_char <= r_char + 1'b1;
            end
            if (r_state == S_IDLE && send) begin
                r_number <= number;
            end else if (r_state == S_STOP && w_bit_end) begin
                r_number <= r_number << 4;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (send) w_next = S_START;
            S_START: if (w_bit_end) w_next = S_DATA;
            S_DATA:  if (w_bit_end && r_bit == 3'd7) w_next = S_STOP;
            S_STOP:  if (w_bit_end) w_next = w_last_char ? S_IDLE : S_START;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = 1'b1;
        case (r_state)
            S_IDLE:  busy = 1'b0;
            S_START: tx   = 1'b0;
            S_DATA:  tx   = w_char[r_bit];
            S_STOP:  tx   = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_number_tx.sv
// tb/tb_uart_number_tx.sv - self-checking bench for uart_number_tx with a cycle-level waveform model.
module tb_uart_number_tx;

    localparam int CPB = 10;
`ifdef UART_NUMBER_TX_CRLF_EN
    localparam int NCH = 6;
`else
    localparam int NCH = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        send = 1'b0;
    logic [15:0] number = 16'h0;
    logic        tx;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    uart_number_tx #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ(1000),
        .BAUD_RATE(100),
        .NUMBER_OF_DIGITS(4),
        .NUMBER_OF_BITS_PER_DIGIT(4)
    ) dut (
        .clk(clk), .rst(rst), .send(send), .number(number),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: each accepted message expands into its per-cycle {tx,busy,done} waveform.
    logic [2:0] exp_q[$];
    logic [2:0] m_cur;
    bit         model_en = 0;

    function automatic logic [2:0] exp_now();
        return (exp_q.size() != 0) ? exp_q[0] : 3'b100;
    endfunction

    function automatic logic [7:0] msg_char(input logic [15:0] num, input int k);
        logic [3:0] n;
        if (k == 4) return 8'h0D;
        if (k == 5) return 8'h0A;
        n = num[4*(3-k) +: 4];
        return (n < 4'd10) ? 8'd48 + {4'h0, n} : 8'd55 + {4'h0, n};
    endfunction

    task automatic push_msg(input logic [15:0] num);
        logic [7:0] c;
        logic       b;
        for (int k = 0; k < NCH; k++) begin
            c = msg_char(num, k);
            for (int i = 0; i < 10; i++) begin
                b = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : c[i-1];
                repeat (CPB) exp_q.push_back({b, 1'b1, 1'b0});
            end
        end
        exp_q.push_back(3'b101);
    endtask

    always @(posedge clk) begin
        m_cur = exp_now();
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (rst) begin
            exp_q.delete();
            model_en = 1;
        end else if (send && !m_cur[1]) begin
            push_msg(number);
        end
    end

    always @(negedge clk) begin
        if (model_en) begin
            n_checks++;
            if ({tx, busy, done} !== exp_now()) begin
                n_errors++;
                $display("FAIL cycle_model at %0t: got tx/busy/done=%b expected %b", $time, {tx, busy, done}, exp_now());
            end
        end
    end

    // Serial receiver and activity counters, independent of the model.
    logic [7:0] rx_q[$];
    logic [7:0] rx_byte;
    bit         rx_active = 0;
    int         rx_cnt = 0;
    int         busy_cnt = 0;
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        if (rx_active) begin
            rx_cnt++;
            if (rx_cnt >= 15 && rx_cnt <= 85 && rx_cnt % 10 == 5) rx_byte[(rx_cnt-15)/10] = tx;
            if (rx_cnt == 95) rx_q.push_back(rx_byte);
            if (rx_cnt == 99) rx_active = 0;
        end else if (model_en && tx === 1'b0) begin
            rx_active = 1;
            rx_cnt = 0;
        end
    end

    always @(posedge clk) if (rst) rx_active = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_stats();
        busy_cnt = 0;
        done_cnt = 0;
        rx_q.delete();
    endtask

    task automatic wait_done(input int budget);
        bit found = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("done_seen", {31'b0, found}, 32'd1);
    endtask

    task automatic check_bytes(input string name, input logic [7:0] exp[6], input int nmsg);
        check({name, "_count"}, rx_q.size(), NCH * nmsg);
        for (int k = 0; k < rx_q.size() && k < NCH * nmsg; k++) begin
            check(name, {24'b0, rx_q[k]}, {24'b0, exp[k % NCH]});
        end
    endtask

    logic [7:0] exp_a[6] = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    logic [7:0] exp_0[6] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    logic [7:0] exp_f[6] = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};

    initial begin
        tick(3);
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Single message of 16'h1A2F
        clear_stats();
        number = 16'h1A2F;
        send = 1'b1;
        tick(1);
        check("start_tx_low", {31'b0, tx}, 32'd0);
        check("start_busy", {31'b0, busy}, 32'd1);
        send = 1'b0;
        wait_done(NCH * 100 + 50);
        check("done_busy_low", {31'b0, busy}, 32'd0);
        tick(1);
        check_bytes("msg_1a2f", exp_a, 1);
        check("busy_cycles", busy_cnt, NCH * 100);
        check("done_pulses", done_cnt, 1);

        // Send and number changes while busy are ignored
        tick(3);
        clear_stats();
        number = 16'h1A2F;
        send = 1'b1;
        tick(1);
        send = 1'b0;
        tick(150);
        number = 16'hFFFF;
        send = 1'b1;
        tick(2);
        send = 1'b0;
        wait_done(NCH * 100 + 50);
        tick(300);
        check_bytes("msg_ignore_send", exp_a, 1);
        check("ignore_done_pulses", done_cnt, 1);
        check("ignore_busy_cycles", busy_cnt, NCH * 100);

        // Reset during the second character's data bits
        clear_stats();
        number = 16'h1A2F;
        send = 1'b1;
        tick(1);
        send = 1'b0;
        tick(130);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("abort_tx", {31'b0, tx}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        tick(200);
        check("abort_no_done", done_cnt, 0);
        clear_stats();
        number = 16'h0000;
        send = 1'b1;
        tick(1);
        send = 1'b0;
        wait_done(NCH * 100 + 50);
        tick(1);
        check_bytes("msg_0000", exp_0, 1);

        // Send held high: back-to-back messages with one idle cycle
        tick(3);
        clear_stats();
        number = 16'hFFFF;
        send = 1'b1;
        wait_done(NCH * 100 + 50);
        check("gap_idle_tx", {31'b0, tx}, 32'd1);
        tick(1);
        check("gap_restart_tx", {31'b0, tx}, 32'd0);
        check("gap_restart_busy", {31'b0, busy}, 32'd1);
        send = 1'b0;
        wait_done(NCH * 100 + 50);
        tick(1);
        check_bytes("msg_ffff_rep", exp_f, 2);
        check("rep_done_pulses", done_cnt, 2);

        // Reset and send in the same cycle
        tick(3);
        clear_stats();
        number = 16'h1234;
        rst = 1'b1;
        send = 1'b1;
        tick(1);
        rst = 1'b0;
        send = 1'b0;
        check("rst_send_tx", {31'b0, tx}, 32'd1);
        check("rst_send_busy", {31'b0, busy}, 32'd0);
        tick(20);
        check("rst_send_no_busy", busy_cnt, 0);

        // Random traffic against the cycle model
        for (int i = 0; i < 15000; i++) begin
            number = 16'($urandom);
            send = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 999) == 0);
            tick(1);
        end
        rst = 1'b0;
        send = 1'b0;
        tick(NCH * 100 + 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_number_tx.md
UART_NUMBER_TX -- requirements
Module: uart_number_tx

Interface
REQ-001 SHALL have parameter BOARD_CLOCK_FREQUENCY_IN_HZ, default 100_000_000, clk frequency.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate.
REQ-003 SHALL have parameter NUMBER_OF_DIGITS, default 4, hex digits sent per message.
REQ-004 SHALL have parameter NUMBER_OF_BITS_PER_DIGIT, fixed at 4, bits per hex digit.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port send, input, 1 bit, message request; sampled every clk.
REQ-008 SHALL have port number, input, NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT bits, value to transmit.
REQ-009 SHALL have port tx, output, 1 bit, UART line, idle high; drives usb_tx.
REQ-010 SHALL have port busy, output, 1 bit, high while a message is in progress.
REQ-011 SHALL have port done, output, 1 bit, one-cycle pulse at message completion.

Function
REQ-012 SHALL use CLKS_PER_BIT = BOARD_CLOCK_FREQUENCY_IN_HZ / BAUD_RATE (integer division, truncation); every bit lasts exactly CLKS_PER_BIT cycles.
REQ-013 SHALL frame each character as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-014 SHALL accept send only in a cycle where busy=0; send while busy=1 is ignored, not queued.
REQ-015 SHALL latch number into an internal register on the accepting cycle; later changes to number do not affect the message in progress.
REQ-016 SHALL assert busy and drive tx=0 (start bit) on the cycle after acceptance (latency 1).
REQ-017 SHALL send digits most-significant first, each as uppercase ASCII: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
REQ-018 SHALL send characters back to back with no idle gap: the next start bit immediately follows the previous stop bit.
REQ-019 SHALL implement FSM states IDLE, START, DATA, STOP; IDLE->START on accepted send; START->DATA after one bit time; DATA->STOP after 8 bits; STOP->START if characters remain, else STOP->IDLE.
REQ-020 SHALL, on STOP->IDLE, pulse done high for exactly one cycle and drive busy low in that same cycle.
REQ-021 SHALL hold tx=1 in IDLE.
REQ-022 SHALL accept a new send on the cycle after done; if send is held high continuously, messages repeat with exactly one idle cycle between messages.

Reset
REQ-023 SHALL, with rst=1 at a clock edge, force tx=1, busy=0, done=0, FSM=IDLE, and clear bit, baud and character counters.
REQ-024 SHALL abort any in-progress frame on reset mid-message; tx goes high the cycle after the reset edge and no done pulse is issued.
REQ-025 SHALL give rst priority over send in the same cycle.

Configuration
REQ-026 SHALL honour macro UART_NUMBER_TX_CRLF_EN: when defined, each message is the NUMBER_OF_DIGITS characters followed by 0x0D, 0x0A; when undefined, the message is the digits only, with no trailing characters.

Verification
All scenarios use BOARD_CLOCK_FREQUENCY_IN_HZ=1000 and BAUD_RATE=100, giving CLKS_PER_BIT=10.
REQ-027 SHALL test: CRLF enabled, number=16'h1A2F, send pulse -> bytes 0x31, 0x41, 0x32, 0x46, 0x0D, 0x0A; busy high for 600 cycles; done pulses once at the end.
REQ-028 SHALL test: CRLF disabled, number=16'h1A2F -> bytes 0x31, 0x41, 0x32, 0x46 only; 400 busy cycles.
REQ-029 SHALL test: send pulsed again and number changed to 16'hFFFF mid-message -> the output is still the original message; no second message is sent.
REQ-030 SHALL test: rst asserted during the second character's data bits -> tx=1 and busy=0 on the next cycle; no done pulse; a following send of 16'h0000 yields 0x30 x4.
REQ-031 SHALL test: send held high, number=16'hFFFF -> consecutive messages of 0x46 x4 (plus CR/LF if enabled), each separated by exactly one idle-high cycle.
REQ-032 SHALL test: rst and send asserted in the same cycle -> no transmission starts; tx stays 1.
